// File: rtl/serdes_pkg.sv
// Shared definitions for the serial byte link (transmitter and receiver).
//   IDLE/SHIFT     : frame state encoding
//   DEFAULT_WIDTH  : default word width in bits
//   LSB_FIRST/MSB_FIRST : bit-order selector values
package serdes_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serdes_state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam bit LSB_FIRST = 1'b0;
  localparam bit MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle of the PISO transmitter.
//   load_valid/load_data/load_ready : upstream word handshake
//   shift_en                        : bit-rate strobe
//   ser_out/ser_valid               : serial bit and its qualifier
//   frame_first/frame_last/busy     : frame markers and activity
interface piso_serializer_if
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);

  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             load_ready;
  logic             shift_en;
  logic             ser_out;
  logic             ser_valid;
  logic             frame_first;
  logic             frame_last;
  logic             busy;

  // Upstream side: supplies words and the bit-rate strobe
  modport master (
    output load_valid, load_data, shift_en,
    input  load_ready, ser_out, ser_valid, frame_first, frame_last, busy
  );

  // Serializer side
  modport slave (
    input  load_valid, load_data, shift_en,
    output load_ready, ser_out, ser_valid, frame_first, frame_last, busy
  );

endinterface

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with frame markers.
//   clk  : rising-edge clock
//   rstb : asynchronous, active-high reset
//   bus  : load handshake in, serial bit stream + frame markers out
// A WIDTH-bit word is accepted on load_valid & load_ready and shifted out
// one bit per clk edge with shift_en=1. A new word may be accepted in the
// last-bit cycle so consecutive frames stream without a gap.
module piso_serializer
  import serdes_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = LSB_FIRST
) (
  input  logic            clk,
  input  logic            rstb,
  piso_serializer_if.slave bus
);

  localparam int unsigned      CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [0:0] ST_IDLE  = 1'(IDLE);
  localparam logic [0:0] ST_SHIFT = 1'(SHIFT);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             in_shift;
  logic             last_bit;
  logic             ready_c;
  logic [WIDTH-1:0] shifted;

  assign in_shift = (state_q == ST_SHIFT);
  assign last_bit = in_shift && (cnt_q == LAST_CNT);

  // Ready in IDLE, or in the enabled last-bit cycle so the next frame abuts
  assign ready_c  = (state_q == ST_IDLE) || (last_bit && bus.shift_en);

  // Move the register toward the output end, zero-filling the far end
  assign shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[WIDTH-1:1]};

  // State, shift register and bit counter
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_valid) begin
          shreg_d = bus.load_data;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bus.shift_en) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (bus.load_valid) begin
              shreg_d = bus.load_data;
            end else begin
              // Clear so ser_out reads 0 while idle
              shreg_d = '0;
              state_d = ST_IDLE;
            end
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode directly from registers; only load_ready sees shift_en
  assign bus.load_ready  = ready_c;
  assign bus.ser_out     = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign bus.ser_valid   = in_shift;
  assign bus.busy        = in_shift;
  assign bus.frame_first = in_shift && (cnt_q == '0);
  assign bus.frame_last  = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: LSB-first instance driven through
// a bit/word scoreboard with a loopback receiver, plus an MSB-first instance.
module tb_piso_serializer;
  import serdes_pkg::*;

  localparam int unsigned W = 8;

  logic clk  = 1'b0;
  logic rstb = 1'b1;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) if_l ();
  piso_serializer_if #(.WIDTH(W)) if_m ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk  (clk),
    .rstb (rstb),
    .bus  (if_l.slave)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk  (clk),
    .rstb (rstb),
    .bus  (if_m.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic b;
    logic first;
    logic last;
  } exp_bit_t;

  exp_bit_t         bit_q[$];
  logic [W-1:0]     word_q[$];
  logic [W-1:0]     rx = '0;
  exp_bit_t         mon_e;
  logic [W-1:0]     mon_w;

  // Expected LSB-first bit stream and reassembled word for one frame
  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < int'(W); i++) begin
      exp_bit_t e;
      e.b     = w[i];
      e.first = (i == 0);
      e.last  = (i == int'(W) - 1);
      bit_q.push_back(e);
    end
    word_q.push_back(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consumed bit of the LSB-first instance
  always @(negedge clk) begin
    if (!rstb && if_l.ser_valid && if_l.shift_en) begin
      checks++;
      if (bit_q.size() == 0) begin
        errors++;
        $display("FAIL sb_extra_bit: got ser_out=%b with no bit expected", if_l.ser_out);
      end else begin
        mon_e = bit_q.pop_front();
        if ({if_l.ser_out, if_l.frame_first, if_l.frame_last} !==
            {mon_e.b, mon_e.first, mon_e.last}) begin
          errors++;
          $display("FAIL sb_bit: got out/first/last=%b%b%b expected %b%b%b",
                   if_l.ser_out, if_l.frame_first, if_l.frame_last,
                   mon_e.b, mon_e.first, mon_e.last);
        end
        rx = {if_l.ser_out, rx[W-1:1]};
        if (mon_e.last && word_q.size() != 0) begin
          checks++;
          mon_w = word_q.pop_front();
          if (rx !== mon_w) begin
            errors++;
            $display("FAIL sb_loopback: got %h expected %h", rx, mon_w);
          end
        end
      end
    end
  end

  task automatic test_reset();
    repeat (2) tick();
    checks++;
    if ({if_l.ser_out, if_l.ser_valid, if_l.busy, if_l.frame_first, if_l.frame_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_held_outputs: got %b expected 00000",
               {if_l.ser_out, if_l.ser_valid, if_l.busy, if_l.frame_first, if_l.frame_last});
    end
    rstb = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_l.ser_out, if_l.ser_valid, if_l.busy, if_l.frame_first, if_l.frame_last} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle_outputs: got %b expected 00000",
               {if_l.ser_out, if_l.ser_valid, if_l.busy, if_l.frame_first, if_l.frame_last});
    end
    checks++;
    if (if_l.load_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_load_ready: got %b expected 1", if_l.load_ready);
    end
    checks++;
    if ({if_m.ser_out, if_m.ser_valid, if_m.busy, if_m.load_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL reset_msb_idle: got %b expected 0001",
               {if_m.ser_out, if_m.ser_valid, if_m.busy, if_m.load_ready});
    end
    tick();
  endtask

  task automatic test_single();
    if_l.load_data  = 8'hA5;
    if_l.load_valid = 1'b1;
    if_l.shift_en   = 1'b1;
    push_word(8'hA5);
    tick();
    if_l.load_valid = 1'b0;
    if_l.load_data  = '0;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      checks++;
      if ({if_l.ser_valid, if_l.busy} !== 2'b11) begin
        errors++;
        $display("FAIL single_valid[%0d]: got valid/busy=%b expected 11", i, {if_l.ser_valid, if_l.busy});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({if_l.ser_out, if_l.ser_valid, if_l.busy} !== 3'b000) begin
      errors++;
      $display("FAIL single_end_idle: got out/valid/busy=%b expected 000",
               {if_l.ser_out, if_l.ser_valid, if_l.busy});
    end
    checks++;
    if (bit_q.size() != 0) begin
      errors++;
      $display("FAIL single_drained: got %0d bits pending expected 0", bit_q.size());
    end
    tick();
  endtask

  task automatic test_back_to_back();
    if_l.load_data  = 8'h3C;
    if_l.load_valid = 1'b1;
    if_l.shift_en   = 1'b1;
    push_word(8'h3C);
    tick();
    if_l.load_data = 8'hF0;
    for (int k = 0; k < int'(W); k++) begin
      if (k == int'(W) - 1) push_word(8'hF0);
      @(negedge clk);
      checks++;
      if (if_l.load_ready !== (k == int'(W) - 1)) begin
        errors++;
        $display("FAIL b2b_load_ready[%0d]: got %b expected %b", k, if_l.load_ready, (k == int'(W) - 1));
      end
      checks++;
      if (if_l.ser_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap_a[%0d]: got ser_valid=%b expected 1", k, if_l.ser_valid);
      end
      tick();
    end
    if_l.load_valid = 1'b0;
    for (int k = 0; k < int'(W); k++) begin
      @(negedge clk);
      checks++;
      if (if_l.ser_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_gap_b[%0d]: got ser_valid=%b expected 1", k, if_l.ser_valid);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (if_l.ser_valid !== 1'b0 || bit_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_end: got ser_valid=%b pending=%0d expected 0 and 0", if_l.ser_valid, bit_q.size());
    end
    tick();
  endtask

  task automatic test_duty();
    logic [W-1:0] w;
    w = 8'h81;
    if_l.shift_en   = 1'b0;
    if_l.load_data  = w;
    if_l.load_valid = 1'b1;
    push_word(w);
    tick();
    if_l.load_data = 8'h5A;
    for (int c = 0; c < 3 * int'(W); c++) begin
      if_l.shift_en = ((c % 3) == 2);
      if (c == 3 * int'(W) - 1) push_word(8'h5A);
      @(negedge clk);
      checks++;
      if (if_l.load_ready !== (c == 3 * int'(W) - 1)) begin
        errors++;
        $display("FAIL duty_load_ready[%0d]: got %b expected %b", c, if_l.load_ready, (c == 3 * int'(W) - 1));
      end
      checks++;
      if ({if_l.ser_valid, if_l.ser_out} !== {1'b1, w[c / 3]}) begin
        errors++;
        $display("FAIL duty_hold[%0d]: got valid/out=%b expected %b", c,
                 {if_l.ser_valid, if_l.ser_out}, {1'b1, w[c / 3]});
      end
      tick();
    end
    if_l.load_valid = 1'b0;
    if_l.shift_en   = 1'b1;
    repeat (W) tick();
    @(negedge clk);
    checks++;
    if (if_l.ser_valid !== 1'b0 || bit_q.size() != 0) begin
      errors++;
      $display("FAIL duty_end: got ser_valid=%b pending=%0d expected 0 and 0", if_l.ser_valid, bit_q.size());
    end
    tick();
  endtask

  task automatic test_msb_first();
    logic [W-1:0] w;
    w = 8'h80;
    if_m.load_data  = w;
    if_m.load_valid = 1'b1;
    if_m.shift_en   = 1'b1;
    tick();
    if_m.load_valid = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      @(negedge clk);
      checks++;
      if ({if_m.ser_valid, if_m.ser_out, if_m.frame_first, if_m.frame_last} !==
          {1'b1, w[int'(W) - 1 - i], (i == 0), (i == int'(W) - 1)}) begin
        errors++;
        $display("FAIL msb_bit[%0d]: got valid/out/first/last=%b expected %b", i,
                 {if_m.ser_valid, if_m.ser_out, if_m.frame_first, if_m.frame_last},
                 {1'b1, w[int'(W) - 1 - i], (i == 0), (i == int'(W) - 1)});
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if ({if_m.ser_valid, if_m.ser_out} !== 2'b00) begin
      errors++;
      $display("FAIL msb_end: got valid/out=%b expected 00", {if_m.ser_valid, if_m.ser_out});
    end
    if_m.shift_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_abort();
    if_l.load_data  = 8'hFF;
    if_l.load_valid = 1'b1;
    if_l.shift_en   = 1'b1;
    push_word(8'hFF);
    tick();
    if_l.load_valid = 1'b0;
    repeat (4) tick();
    #2;
    rstb = 1'b1;
    #1;
    checks++;
    if ({if_l.ser_out, if_l.ser_valid, if_l.busy, if_l.frame_first, if_l.frame_last} !== 5'b0) begin
      errors++;
      $display("FAIL abort_async_outputs: got %b expected 00000",
               {if_l.ser_out, if_l.ser_valid, if_l.busy, if_l.frame_first, if_l.frame_last});
    end
    bit_q.delete();
    word_q.delete();
    rx = '0;
    if_l.shift_en = 1'b0;
    tick();
    rstb = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_l.ser_valid, if_l.busy, if_l.load_ready} !== 3'b001) begin
      errors++;
      $display("FAIL abort_idle: got valid/busy/ready=%b expected 001",
               {if_l.ser_valid, if_l.busy, if_l.load_ready});
    end
    tick();
    if_l.load_data  = 8'h01;
    if_l.load_valid = 1'b1;
    if_l.shift_en   = 1'b1;
    push_word(8'h01);
    tick();
    if_l.load_valid = 1'b0;
    repeat (W) tick();
    @(negedge clk);
    checks++;
    if (if_l.ser_valid !== 1'b0 || bit_q.size() != 0) begin
      errors++;
      $display("FAIL abort_resend_end: got ser_valid=%b pending=%0d expected 0 and 0",
               if_l.ser_valid, bit_q.size());
    end
    tick();
  endtask

  initial begin
    if_l.load_valid = 1'b0;
    if_l.load_data  = '0;
    if_l.shift_en   = 1'b0;
    if_m.load_valid = 1'b0;
    if_m.load_data  = '0;
    if_m.shift_en   = 1'b0;

    test_reset();
    test_single();
    test_back_to_back();
    test_duty();
    test_msb_first();
    test_reset_abort();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in, serial-out transmitter: the sending end of the team's serial byte link, feeding the serial-in shift register at the far end. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per enabled clock, with frame markers. Default bit order is LSB first, so a receiver that shifts each new bit into its MSB and shifts right reassembles the word unchanged after WIDTH bits. Back-to-back words stream with no idle gap.

Parameters:
WIDTH, 8, word width in bits; must be 2 or more.
MSB_FIRST, 0, 0 = LSB sent first; 1 = MSB sent first.

Ports:
clk  in  1  rising-edge clock
rstb  in  1  reset: asynchronous, active-high
load_valid  in  1  upstream word available
load_data  in  WIDTH  word to transmit; sampled on handshake
load_ready  out  1  block can accept a word this cycle
shift_en  in  1  bit-rate strobe; current bit is consumed on a clk edge with shift_en=1
ser_out  out  1  serial data bit
ser_valid  out  1  ser_out carries a frame bit
frame_first  out  1  current bit is bit 0 of the frame
frame_last  out  1  current bit is the final bit of the frame
busy  out  1  frame in progress (state == SHIFT)

Behaviour:
- State machine with states IDLE and SHIFT. Registers: shreg[WIDTH-1:0] and bit counter cnt[$clog2(WIDTH)-1:0].
- Reset (rstb=1, asynchronous, at any time): state=IDLE, shreg=0, cnt=0. ser_out, ser_valid, busy, frame_first and frame_last are all 0. A frame in flight is aborted and its bits are not resumed.
- Handshake: a word is accepted on a clk edge where load_valid=1 and load_ready=1. load_data must be stable only in that cycle.
- load_ready is combinational: 1 in IDLE; 1 in SHIFT only when cnt==WIDTH-1 and shift_en=1. Otherwise it is 0.
- While load_ready=0, load_valid is ignored. Upstream holds the word; no data is lost or overwritten.
- IDLE:
  - ser_valid=0 and ser_out=0.
  - On accept: shreg<=load_data, cnt<=0, go to SHIFT.
  - shift_en has no effect.
- SHIFT:
  - ser_valid=1 and busy=1.
  - ser_out=shreg[0] when MSB_FIRST=0, or shreg[WIDTH-1] when MSB_FIRST=1. It is driven directly from a register; no combinational path from inputs.
  - frame_first = (cnt==0). frame_last = (cnt==WIDTH-1).
  - shift_en=0: everything holds. The bit stays on ser_out indefinitely.
  - shift_en=1 and cnt<WIDTH-1: shreg shifts toward the output end (right for LSB-first, left for MSB-first), a 0 fills the vacated end, and cnt<=cnt+1.
  - shift_en=1 and cnt==WIDTH-1, with load_valid=1: the new word is accepted in the same cycle. shreg<=load_data, cnt<=0, stay in SHIFT. The next frame's bit 0 follows the previous last bit with no gap.
  - shift_en=1 and cnt==WIDTH-1, with load_valid=0: go to IDLE, cnt<=0.
- Latency: the accept edge is followed by bit 0 on ser_out in the next cycle. With shift_en held at 1, one frame occupies exactly WIDTH consecutive cycles.
- The counter never wraps past WIDTH-1. It is only reset to 0 by a reload or a return to IDLE.

Decomposition:
- Shared package serdes_pkg holds the state enum (IDLE, SHIFT), the default WIDTH constant (8) and the bit-order constants (LSB_FIRST=0, MSB_FIRST=1). The matching receiver imports the same package.
- Single module. No sub-module is warranted; the counter and shift register are inline.

Test Plan:
1. Reset then idle: rstb pulse with no load_valid -> all outputs 0, load_ready=1, busy=0.
2. Single word, WIDTH=8, LSB-first, 0xA5, shift_en=1 continuous -> ser_out 1,0,1,0,0,1,0,1 over 8 cycles. frame_first in cycle 1, frame_last in cycle 8, then ser_valid=0. A loopback receiver reads 0xA5.
3. Back-to-back words 0x3C then 0xF0 with load_valid held -> load_ready pulses only in the last-bit cycle. 16 contiguous valid bits 0,0,1,1,1,1,0,0,0,0,0,0,1,1,1,1 with no gap.
4. shift_en duty 1-in-3 while sending 0x81 -> each bit is held for 3 cycles, 24 cycles total, bit order unchanged. load_valid during the frame is not accepted until the last-bit enabled cycle.
5. MSB_FIRST=1 sending 0x80 -> ser_out 1 then seven 0s.
6. Reset asserted after bit 3 of 0xFF -> outputs 0 immediately, without waiting for a clk edge. After release the state is IDLE. A new word 0x01 is sent from bit 0 with no residue of 0xFF.
